// File: rtl/wav_buf_ctrl_pkg.sv
// wav_buf_ctrl_pkg: state encoding and default widths for the record/playback buffer.
// Optional build macro: WAV_LOOP_PLAY_EN (playback wraps instead of stopping).
package wav_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REC  = 2'b01,
        ST_PLAY = 2'b10
    } state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_RAM_LAT = 1;

endpackage

// File: rtl/wav_buf_ctrl_if.sv
// wav_buf_ctrl_if: codec-driver strobes plus the single-port sample RAM bus.
// master = the buffer controller, slave = codec driver / RAM side.
interface wav_buf_ctrl_if
    import wav_buf_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              record_en;
    logic              play_en;
    logic              wav_wren;
    logic [DATA_W-1:0] wav_in_data;
    logic              wav_rden;
    logic [DATA_W-1:0] wav_out_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output record_en, play_en, wav_out_data,
        output ram_addr, ram_we, ram_wdata,
        input  wav_wren, wav_in_data, wav_rden, ram_rdata
    );

    modport slave (
        input  record_en, play_en, wav_out_data,
        input  ram_addr, ram_we, ram_wdata,
        output wav_wren, wav_in_data, wav_rden, ram_rdata
    );

endinterface

// File: rtl/wav_buf_ctrl_ptr_cnt.sv
// wav_buf_ctrl_ptr_cnt: pointer counter with synchronous clear and increment.
// Clear wins over increment.
module wav_buf_ctrl_ptr_cnt #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/wav_buf_ctrl.sv
// wav_buf_ctrl: record/playback sequencer owning one single-port sample RAM.
// Build macro WAV_LOOP_PLAY_EN: playback wraps to sample 0 instead of ending.
module wav_buf_ctrl
    import wav_buf_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RAM_LAT = DEF_RAM_LAT
) (
    input  logic            clk50M,
    input  logic            rst_n,
    input  logic            btn_rec,
    input  logic            btn_play,
    input  logic            btn_stop,
    wav_buf_ctrl_if.master  bus,
    output logic [1:0]      state,
    output logic [ADDR_W:0] rec_len,
    output logic            underrun
);

    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t             cur, nxt;
    logic [ADDR_W:0]    wr_ptr, rd_ptr;
    logic [RAM_LAT-1:0] pipe, pipe_nx;
    logic               rd_req, busy;
    logic               go_rec, play_btn, go_play;
    logic               wr_acc, rd_acc, rd_wrap, issue;

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) cur <= ST_IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        go_rec   = 1'b0;
        play_btn = 1'b0;
        go_play  = 1'b0;
        wr_acc   = 1'b0;
        rd_acc   = 1'b0;
        rd_wrap  = 1'b0;
        issue    = 1'b0;
        unique case (cur)
            ST_IDLE: begin
                if (btn_stop) begin
                    nxt = ST_IDLE;
                end else if (btn_rec) begin
                    go_rec = 1'b1;
                    nxt    = ST_REC;
                end else if (btn_play) begin
                    play_btn = 1'b1;
                    // first read goes out in the button cycle itself
                    if (rec_len != '0) begin
                        go_play = 1'b1;
                        issue   = 1'b1;
                        nxt     = ST_PLAY;
                    end
                end
            end
            ST_REC: begin
                if (btn_stop) begin
                    nxt = ST_IDLE;
                end else if (bus.wav_wren) begin
                    wr_acc = 1'b1;
                    if (wr_ptr == LAST) nxt = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (btn_stop) begin
                    nxt = ST_IDLE;
                end
`ifdef WAV_LOOP_PLAY_EN
                else begin
                    issue   = rd_req;
                    rd_acc  = bus.wav_rden;
                    rd_wrap = bus.wav_rden
                           && (rd_ptr + (ADDR_W+1)'(1) == rec_len);
                end
`else
                else if (rd_ptr == rec_len) begin
                    nxt = ST_IDLE;
                end else begin
                    issue  = rd_req;
                    rd_acc = bus.wav_rden;
                end
`endif
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pipe_nx    = '0;
        pipe_nx[0] = issue;
        for (int i = 1; i < RAM_LAT; i++) pipe_nx[i] = pipe[i-1];
    end

    assign busy = rd_req | (|pipe);

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            pipe             <= '0;
            rd_req           <= 1'b0;
            bus.play_en      <= 1'b0;
            bus.wav_out_data <= '0;
            underrun         <= 1'b0;
        end else begin
            if (nxt != ST_PLAY) begin
                pipe             <= '0;
                rd_req           <= 1'b0;
                bus.play_en      <= 1'b0;
                bus.wav_out_data <= '0;
            end else begin
                pipe   <= pipe_nx;
                rd_req <= rd_acc;
                if (pipe[RAM_LAT-1]) begin
                    bus.wav_out_data <= bus.ram_rdata;
                    bus.play_en      <= 1'b1;
                end
            end
            if (go_rec || play_btn) underrun <= 1'b0;
            else if (rd_acc && busy) underrun <= 1'b1;
        end
    end

    wav_buf_ctrl_ptr_cnt #(.W(ADDR_W+1)) u_wr_ptr (
        .clk   (clk50M),
        .rst_n (rst_n),
        .clr   (go_rec),
        .inc   (wr_acc),
        .cnt   (wr_ptr)
    );

    wav_buf_ctrl_ptr_cnt #(.W(ADDR_W+1)) u_rd_ptr (
        .clk   (clk50M),
        .rst_n (rst_n),
        .clr   (go_play | rd_wrap),
        .inc   (rd_acc),
        .cnt   (rd_ptr)
    );

    assign rec_len       = wr_ptr;
    assign state         = cur;
    assign bus.record_en = (cur == ST_REC);
    assign bus.ram_we    = wr_acc;
    assign bus.ram_wdata = wr_acc ? bus.wav_in_data : '0;
    assign bus.ram_addr  = (cur == ST_REC)  ? wr_ptr[ADDR_W-1:0] :
                           (cur == ST_PLAY) ? rd_ptr[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_wav_buf_ctrl.sv
// tb_wav_buf_ctrl: directed bench for wav_buf_ctrl with a 1-cycle behavioural RAM.
// Build with WAV_LOOP_PLAY_EN to exercise looping playback.
`timescale 1ns/1ps
module tb_wav_buf_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int LAT = 1;

    logic          clk50M   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          btn_rec  = 1'b0;
    logic          btn_play = 1'b0;
    logic          btn_stop = 1'b0;
    logic [1:0]    state;
    logic [AW:0]   rec_len;
    logic          underrun;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            total = 0;
    int            bad   = 0;

    wav_buf_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wav_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT)) dut (
        .clk50M   (clk50M),
        .rst_n    (rst_n),
        .btn_rec  (btn_rec),
        .btn_play (btn_play),
        .btn_stop (btn_stop),
        .bus      (bus),
        .state    (state),
        .rec_len  (rec_len),
        .underrun (underrun)
    );

    always #5 clk50M = ~clk50M;

    always @(posedge clk50M) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic tick;
        @(posedge clk50M);
        #1;
    endtask

    task automatic press(input logic r, input logic p, input logic s);
        btn_rec  = r;
        btn_play = p;
        btn_stop = s;
        tick();
        btn_rec  = 1'b0;
        btn_play = 1'b0;
        btn_stop = 1'b0;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        bus.wav_in_data = d;
        bus.wav_wren    = 1'b1;
        tick();
        bus.wav_wren    = 1'b0;
        tick();
    endtask

    task automatic rd;
        bus.wav_rden = 1'b1;
        tick();
        bus.wav_rden = 1'b0;
    endtask

    task automatic record5;
        press(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) wr(DW'(k * 257));
        press(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        #3;
        total++;
        if ({state, rec_len, underrun, bus.record_en, bus.play_en, bus.ram_we} !== '0) begin
            bad++;
            $display("FAIL reset_status: st=%b len=%0d ur=%b rec=%b play=%b we=%b want 0",
                     state, rec_len, underrun, bus.record_en, bus.play_en, bus.ram_we);
        end
        total++;
        if ({bus.wav_out_data, bus.ram_addr, bus.ram_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_data: out=%h addr=%h wdata=%h want 0",
                     bus.wav_out_data, bus.ram_addr, bus.ram_wdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
        press(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) wr(DW'(16'h00A0 + k));
        total++;
        if (rec_len !== 5'd5) begin
            bad++;
            $display("FAIL midrec_len: got=%0d want=5", rec_len);
        end
        bus.wav_in_data = 16'hBEEF;
        bus.wav_wren    = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({state, rec_len, bus.record_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== '0) begin
            bad++;
            $display("FAIL midrec_reset: st=%b len=%0d rec=%b we=%b addr=%h wd=%h want 0",
                     state, rec_len, bus.record_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        bus.wav_wren = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_record_stop;
        press(1'b1, 1'b0, 1'b0);
        total++;
        if ({state, bus.record_en, rec_len} !== {2'b01, 1'b1, 5'd0}) begin
            bad++;
            $display("FAIL rec_entry: st=%b rec=%b len=%0d want 01 1 0",
                     state, bus.record_en, rec_len);
        end
        for (int k = 1; k <= 5; k++) begin
            bus.wav_in_data = DW'(k * 257);
            bus.wav_wren    = 1'b1;
            #1;
            total++;
            if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, AW'(k - 1), DW'(k * 257)}) begin
                bad++;
                $display("FAIL rec_write%0d: we=%b addr=%h wd=%h want 1 %h %h",
                         k, bus.ram_we, bus.ram_addr, bus.ram_wdata, k - 1, k * 257);
            end
            tick();
            bus.wav_wren = 1'b0;
            tick();
        end
        btn_stop        = 1'b1;
        bus.wav_in_data = 16'hDEAD;
        bus.wav_wren    = 1'b1;
        #1;
        total++;
        if (bus.ram_we !== 1'b0) begin
            bad++;
            $display("FAIL stop_drops_wren: we=%b want 0", bus.ram_we);
        end
        tick();
        btn_stop     = 1'b0;
        bus.wav_wren = 1'b0;
        total++;
        if ({state, bus.record_en, rec_len} !== {2'b00, 1'b0, 5'd5}) begin
            bad++;
            $display("FAIL rec_stop: st=%b rec=%b len=%0d want 00 0 5",
                     state, bus.record_en, rec_len);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (mem[k] !== DW'((k + 1) * 257)) begin
                bad++;
                $display("FAIL ram_word%0d: got=%h want=%h", k, mem[k], (k + 1) * 257);
            end
        end
        total++;
        if (mem[5] !== 16'h0000) begin
            bad++;
            $display("FAIL ram_word5: got=%h want=0000", mem[5]);
        end
    endtask

    task automatic test_record_full;
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            wr(DW'(16'h1000 + i));
            if (i == 14) begin
                total++;
                if ({state, rec_len} !== {2'b01, 5'd15}) begin
                    bad++;
                    $display("FAIL full_minus1: st=%b len=%0d want 01 15", state, rec_len);
                end
            end
        end
        total++;
        if ({state, bus.record_en, rec_len} !== {2'b00, 1'b0, 5'd16}) begin
            bad++;
            $display("FAIL full_stop: st=%b rec=%b len=%0d want 00 0 16",
                     state, bus.record_en, rec_len);
        end
        bus.wav_in_data = 16'hFFFF;
        bus.wav_wren    = 1'b1;
        #1;
        total++;
        if (bus.ram_we !== 1'b0) begin
            bad++;
            $display("FAIL full_17th: we=%b want 0", bus.ram_we);
        end
        tick();
        bus.wav_wren = 1'b0;
        total++;
        if ({mem[0], mem[15], rec_len} !== {16'h1000, 16'h100F, 5'd16}) begin
            bad++;
            $display("FAIL full_nowrap: m0=%h m15=%h len=%0d want 1000 100f 16",
                     mem[0], mem[15], rec_len);
        end
    endtask

    task automatic test_play;
        record5();
        btn_play = 1'b1;
        tick();
        btn_play = 1'b0;
        total++;
        if ({state, bus.play_en} !== {2'b10, 1'b0}) begin
            bad++;
            $display("FAIL play_early: st=%b play=%b want 10 0", state, bus.play_en);
        end
        tick();
        total++;
        if ({bus.play_en, bus.wav_out_data} !== {1'b1, 16'h0101}) begin
            bad++;
            $display("FAIL play_first: play=%b out=%h want 1 0101", bus.play_en, bus.wav_out_data);
        end
        for (int k = 2; k <= 5; k++) begin
            rd();
            repeat (1000) tick();
            total++;
            if ({bus.wav_out_data, underrun} !== {DW'(k * 257), 1'b0}) begin
                bad++;
                $display("FAIL play_sample%0d: out=%h ur=%b want %h 0",
                         k, bus.wav_out_data, underrun, k * 257);
            end
        end
        rd();
        repeat (5) tick();
`ifdef WAV_LOOP_PLAY_EN
        total++;
        if ({state, bus.play_en, bus.wav_out_data} !== {2'b10, 1'b1, 16'h0101}) begin
            bad++;
            $display("FAIL play_wrap: st=%b play=%b out=%h want 10 1 0101",
                     state, bus.play_en, bus.wav_out_data);
        end
`else
        total++;
        if ({state, bus.play_en, bus.wav_out_data} !== {2'b00, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL play_end: st=%b play=%b out=%h want 00 0 0000",
                     state, bus.play_en, bus.wav_out_data);
        end
`endif
        press(1'b0, 1'b0, 1'b1);
        total++;
        if ({state, bus.play_en, bus.wav_out_data} !== '0) begin
            bad++;
            $display("FAIL play_stop: st=%b play=%b out=%h want 0",
                     state, bus.play_en, bus.wav_out_data);
        end
    endtask

    task automatic test_stop_inflight;
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        total++;
        if ({state, bus.play_en, bus.wav_out_data} !== '0) begin
            bad++;
            $display("FAIL stop_inflight: st=%b play=%b out=%h want 0",
                     state, bus.play_en, bus.wav_out_data);
        end
        repeat (3) tick();
        total++;
        if ({bus.play_en, bus.wav_out_data} !== '0) begin
            bad++;
            $display("FAIL stop_discard: play=%b out=%h want 0", bus.play_en, bus.wav_out_data);
        end
    endtask

    task automatic test_empty_priority;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        rd();
        tick();
        total++;
        if ({state, bus.play_en, rec_len, bus.wav_out_data} !== '0) begin
            bad++;
            $display("FAIL empty_play: st=%b play=%b len=%0d out=%h want 0",
                     state, bus.play_en, rec_len, bus.wav_out_data);
        end
        press(1'b1, 1'b1, 1'b0);
        total++;
        if (state !== 2'b01) begin
            bad++;
            $display("FAIL rec_over_play: st=%b want 01", state);
        end
        press(1'b1, 1'b0, 1'b1);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL stop_over_rec_inrec: st=%b want 00", state);
        end
        press(1'b1, 1'b0, 1'b1);
        total++;
        if ({state, bus.record_en} !== 3'b000) begin
            bad++;
            $display("FAIL stop_over_rec_idle: st=%b rec=%b want 00 0", state, bus.record_en);
        end
    endtask

    task automatic test_underrun;
        record5();
        press(1'b0, 1'b1, 1'b0);
        tick();
        total++;
        if ({bus.play_en, underrun} !== 2'b10) begin
            bad++;
            $display("FAIL ur_start: play=%b ur=%b want 1 0", bus.play_en, underrun);
        end
        bus.wav_rden = 1'b1;
        tick();
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL ur_first_rden: ur=%b want 0", underrun);
        end
        tick();
        bus.wav_rden = 1'b0;
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL ur_set: ur=%b want 1", underrun);
        end
        repeat (10) tick();
        total++;
        if ({underrun, bus.wav_out_data} !== {1'b1, 16'h0303}) begin
            bad++;
            $display("FAIL ur_sticky: ur=%b out=%h want 1 0303", underrun, bus.wav_out_data);
        end
        press(1'b0, 1'b0, 1'b1);
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL ur_after_stop: ur=%b want 1", underrun);
        end
        press(1'b0, 1'b1, 1'b0);
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL ur_clear: ur=%b want 0", underrun);
        end
        press(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.wav_wren    = 1'b0;
        bus.wav_rden    = 1'b0;
        bus.wav_in_data = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_record_stop();
        test_record_full();
        test_play();
        test_stop_inflight();
        test_empty_priority();
        test_underrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
